aes128_decrypt: RTL and testbench

Iterative AES-128 inverse cipher (FIPS-197 §5.3): accepts a 128-bit ciphertext and 128-bit cipher key and returns the plaintext after a fixed latency. It is the decryption counterpart of the `AES128` encryption core and uses the same four-32-bit-word port packing, so the two cores sit side by side and round-trip data. It performs one round per cycle. The round keys are derived on the fly: a forward schedule runs up to rk10, then the schedule is inverted back to rk0. No round-key storage is used.

---
 rtl/aes128_decrypt_pkg.sv | 109 ++++++++++
 rtl/forward_substitution_box.sv | 9 +
 rtl/inv_substitution_box.sv | 9 +
 rtl/aes128_decrypt.sv | 138 +++++++++++++
 tb/tb_aes128_decrypt.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes128_decrypt_pkg.sv
// Shared AES-128 definitions: FSM encodings, Rcon, GF(2^8) arithmetic and byte permutations.
package aes128_decrypt_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KEXP  = 3'd1,
        S_INIT  = 3'd2,
        S_ROUND = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, bb;
        p  = 8'h00;
        x  = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ x;
            x  = xtime(x);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse, and conveniently maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r, sq;
        r  = 8'h01;
        sq = a;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] a);
        return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Byte k of the block sits in b[15-k]; row r of column c is byte r+4c.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [15:0][7:0] b;
        b = s;
        return {b[15], b[2],  b[5],  b[8],
                b[11], b[14], b[1],  b[4],
                b[7],  b[10], b[13], b[0],
                b[3],  b[6],  b[9],  b[12]};
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4], m11 [4], m13 [4], m14 [4];
        logic [7:0] x2, x4, x8;
        a[0] = col[31:24];
        a[1] = col[23:16];
        a[2] = col[15:8];
        a[3] = col[7:0];
        for (int k = 0; k < 4; k++) begin
            x2     = xtime(a[k]);
            x4     = xtime(x2);
            x8     = xtime(x4);
            m9[k]  = x8 ^ a[k];
            m11[k] = x8 ^ x2 ^ a[k];
            m13[k] = x8 ^ x4 ^ a[k];
            m14[k] = x8 ^ x4 ^ x2;
        end
        return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
                inv_mix_col(s[63:32]),  inv_mix_col(s[31:0])};
    endfunction

endpackage

// File: rtl/forward_substitution_box.sv
// 8-bit combinational AES S-box, used by the on-the-fly key schedule.
module forward_substitution_box
    import aes128_decrypt_pkg::*;
(
    input  logic [7:0] in_byte_i,
    output logic [7:0] out_byte_o
);
    assign out_byte_o = sbox_fwd(in_byte_i);
endmodule

// File: rtl/inv_substitution_box.sv
// 8-bit combinational AES inverse S-box for the decryption data path.
module inv_substitution_box
    import aes128_decrypt_pkg::*;
(
    input  logic [7:0] in_byte_i,
    output logic [7:0] out_byte_o
);
    assign out_byte_o = sbox_inv(in_byte_i);
endmodule

// File: rtl/aes128_decrypt.sv
// Iterative AES-128 inverse cipher, one round per cycle; round keys are rolled forward
// to rk10 and then unrolled back to rk0 so no key storage is needed.
module aes128_decrypt
    import aes128_decrypt_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] inp_data_0,
    input  logic [31:0] inp_data_1,
    input  logic [31:0] inp_data_2,
    input  logic [31:0] inp_data_3,
    input  logic [31:0] inp_key_0,
    input  logic [31:0] inp_key_1,
    input  logic [31:0] inp_key_2,
    input  logic [31:0] inp_key_3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data_0,
    output logic [31:0] out_data_1,
    output logic [31:0] out_data_2,
    output logic [31:0] out_data_3
);
    state_t       state_q, state_d;
    logic [127:0] st_q, st_d, kr_q, kr_d, out_q, out_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         ov_q, ov_d;

    logic [127:0] isr, isb, ark, imc;
    assign isr = inv_shift_rows(st_q);

    for (genvar i = 0; i < 16; i++) begin : g_isb
        inv_substitution_box u_isb (
            .in_byte_i  (isr[8*i +: 8]),
            .out_byte_o (isb[8*i +: 8])
        );
    end

    assign ark = isb ^ kr_q;
    assign imc = inv_mix_columns(ark);

    // One SubWord serves both directions: forward uses w3, inverse the recovered w3.
    logic [31:0]  k0, k1, k2, k3, w3_prev, sb_in, sb_out, rc_word;
    logic [127:0] kr_fwd, kr_inv;
    assign {k0, k1, k2, k3} = kr_q;
    assign w3_prev = k3 ^ k2;
    assign sb_in   = rot_word((state_q == S_KEXP) ? k3 : w3_prev);
    assign rc_word = {rcon(rnd_q), 24'h000000};

    for (genvar j = 0; j < 4; j++) begin : g_ksb
        forward_substitution_box u_ksb (
            .in_byte_i  (sb_in[8*j +: 8]),
            .out_byte_o (sb_out[8*j +: 8])
        );
    end

    logic [31:0] f0, f1, f2, f3;
    assign f0     = k0 ^ sb_out ^ rc_word;
    assign f1     = k1 ^ f0;
    assign f2     = k2 ^ f1;
    assign f3     = k3 ^ f2;
    assign kr_fwd = {f0, f1, f2, f3};
    assign kr_inv = {k0 ^ sb_out ^ rc_word, k1 ^ k0, k2 ^ k1, w3_prev};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            st_q    <= '0;
            kr_q    <= '0;
            rnd_q   <= '0;
            ov_q    <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            kr_q    <= kr_d;
            rnd_q   <= rnd_d;
            ov_q    <= ov_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        kr_d    = kr_q;
        rnd_d   = rnd_q;
        ov_d    = ov_q;
        out_d   = out_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    st_d    = {inp_data_3, inp_data_2, inp_data_1, inp_data_0};
                    kr_d    = {inp_key_3, inp_key_2, inp_key_1, inp_key_0};
                    rnd_d   = 4'd1;
                    state_d = S_KEXP;
                end
            end
            S_KEXP: begin
                kr_d = kr_fwd;
                // rnd stays at 10 so INIT unrolls with Rcon[10].
                if (rnd_q == 4'd10) state_d = S_INIT;
                else                rnd_d   = rnd_q + 4'd1;
            end
            S_INIT: begin
                st_d    = st_q ^ kr_q;
                kr_d    = kr_inv;
                rnd_d   = 4'd9;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                if (rnd_q != 4'd0) begin
                    st_d  = imc;
                    kr_d  = kr_inv;
                    rnd_d = rnd_q - 4'd1;
                end else begin
                    st_d    = ark;
                    out_d   = ark;
                    ov_d    = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = ov_q;
    assign {out_data_3, out_data_2, out_data_1, out_data_0} = out_q;

endmodule

// File: tb/tb_aes128_decrypt.sv
// Bench for aes128_decrypt against a byte-matrix AES model with table-built S-boxes.
module tb_aes128_decrypt;

    logic        clk, reset, in_valid, in_ready, out_valid, out_ready;
    logic [127:0] ct_in, key_in, out_blk;
    logic [31:0] od0, od1, od2, od3;

    int n_pass = 0;
    int n_chk  = 0;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] PT_LB  = 128'h4142434445464748494a4b4c4d4e4f43;

    aes128_decrypt dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .inp_data_0 (ct_in[31:0]),
        .inp_data_1 (ct_in[63:32]),
        .inp_data_2 (ct_in[95:64]),
        .inp_data_3 (ct_in[127:96]),
        .inp_key_0  (key_in[31:0]),
        .inp_key_1  (key_in[63:32]),
        .inp_key_2  (key_in[95:64]),
        .inp_key_3  (key_in[127:96]),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data_0 (od0),
        .out_data_1 (od1),
        .out_data_2 (od2),
        .out_data_3 (od3)
    );
    assign out_blk = {od3, od2, od1, od0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef logic [10:0][127:0] rks_t;
    logic [7:0] sb [256];
    logic [7:0] isb_t [256];

    task automatic build_sbox;
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb_t[sb[i]] = i[7:0];
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, bb;
        p = 0; x = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ x;
            x  = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic rks_t key_sched(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rks_t        r;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k < 11; k++) r[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        return r;
    endfunction

    function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input logic [127:0] key);
        rks_t rk;
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] cf [4];
        logic [127:0] v;
        rk = key_sched(key);
        cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        v  = ct ^ rk[10];
        for (int k = 0; k < 16; k++) s[k] = v[127-8*k -: 8];
        for (int rd = 9; rd >= 0; rd--) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r+4*c] = isb_t[s[r+4*((c-r+4)%4)]] ^ rk[rd][127-8*(r+4*c) -: 8];
            if (rd > 0) begin
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) begin
                        s[r+4*c] = 8'h00;
                        for (int k = 0; k < 4; k++)
                            s[r+4*c] = s[r+4*c] ^ gmul(cf[(k-r+4)%4], t[k+4*c]);
                    end
            end else begin
                s = t;
            end
        end
        for (int k = 0; k < 16; k++) v[127-8*k -: 8] = s[k];
        return v;
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] key);
        rks_t rk;
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] cf [4];
        logic [127:0] v;
        rk = key_sched(key);
        cf = '{8'h02, 8'h03, 8'h01, 8'h01};
        v  = pt ^ rk[0];
        for (int k = 0; k < 16; k++) s[k] = v[127-8*k -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r+4*c] = sb[s[r+4*((c+r)%4)]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    if (rd < 10) begin
                        s[r+4*c] = 8'h00;
                        for (int k = 0; k < 4; k++)
                            s[r+4*c] = s[r+4*c] ^ gmul(cf[(k-r+4)%4], t[k+4*c]);
                    end else begin
                        s[r+4*c] = t[r+4*c];
                    end
                    s[r+4*c] = s[r+4*c] ^ rk[rd][127-8*(r+4*c) -: 8];
                end
        end
        for (int k = 0; k < 16; k++) v[127-8*k -: 8] = s[k];
        return v;
    endfunction

    // ---------------- drivers ----------------
    task automatic start(input logic [127:0] ct, input logic [127:0] key);
        ct_in    = ct;
        key_in   = key;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic handshake;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        #12;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_chk++; if (out_blk !== 128'h0) $display("FAIL reset_out_data: got %h want 0", out_blk); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_fips_c1;
        int lat;
        start(CT_C1, KEY_C1);
        wait_out(lat);
        n_chk++; if (lat !== 21) $display("FAIL c1_latency: got %0d want 21", lat); else n_pass++;
        n_chk++; if (out_blk !== PT_C1) $display("FAIL c1_pt: got %h want %h", out_blk, PT_C1); else n_pass++;
        handshake();
    endtask

    task automatic test_fips_b;
        int lat;
        start(CT_B, KEY_B);
        wait_out(lat);
        n_chk++; if (lat !== 21) $display("FAIL appb_latency: got %0d want 21", lat); else n_pass++;
        n_chk++; if (out_blk !== PT_B) $display("FAIL appb_pt: got %h want %h", out_blk, PT_B); else n_pass++;
        handshake();
    endtask

    task automatic test_loopback;
        int lat;
        start(ref_encrypt(PT_LB, KEY_C1), KEY_C1);
        wait_out(lat);
        n_chk++; if (lat !== 21) $display("FAIL loop_latency: got %0d want 21", lat); else n_pass++;
        n_chk++; if (out_blk !== PT_LB) $display("FAIL loop_pt: got %h want %h", out_blk, PT_LB); else n_pass++;
        handshake();
    endtask

    task automatic test_random;
        int lat;
        logic [127:0] ct, key, exp;
        for (int n = 0; n < 6; n++) begin
            ct  = {$urandom(), $urandom(), $urandom(), $urandom()};
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            exp = ref_decrypt(ct, key);
            start(ct, key);
            wait_out(lat);
            n_chk++; if (lat !== 21) $display("FAIL rand_latency[%0d]: got %0d want 21", n, lat); else n_pass++;
            n_chk++; if (out_blk !== exp) $display("FAIL rand_pt[%0d]: got %h want %h", n, out_blk, exp); else n_pass++;
            handshake();
        end
    endtask

    task automatic test_backpressure;
        int lat;
        logic [127:0] ct, key, exp;
        ct  = {$urandom(), $urandom(), $urandom(), $urandom()};
        key = {$urandom(), $urandom(), $urandom(), $urandom()};
        exp = ref_decrypt(ct, key);
        start(ct, key);
        wait_out(lat);
        n_chk++; if (lat !== 21) $display("FAIL bp_latency: got %0d want 21", lat); else n_pass++;
        for (int i = 0; i < 50; i++) begin
            n_chk++; if (out_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); else n_pass++;
            n_chk++; if (out_blk !== exp) $display("FAIL bp_data[%0d]: got %h want %h", i, out_blk, exp); else n_pass++;
            n_chk++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); else n_pass++;
            if (i == 10) begin
                ct_in    = ~ct;
                key_in   = ~key;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        handshake();
        n_chk++; if (out_valid !== 1'b0) $display("FAIL bp_post_valid: got %b want 0", out_valid); else n_pass++;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL bp_post_in_ready: got %b want 1", in_ready); else n_pass++;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            n_chk++; if (out_valid !== 1'b0) $display("FAIL bp_pulse_ignored[%0d]: got %b want 0", i, out_valid); else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        start(CT_C1, KEY_C1);
        repeat (14) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL rmid_valid: got %b want 0", out_valid); else n_pass++;
        n_chk++; if (out_blk !== 128'h0) $display("FAIL rmid_data: got %h want 0", out_blk); else n_pass++;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL rmid_in_ready: got %b want 1", in_ready); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        start(CT_C1, KEY_C1);
        wait_out(lat);
        n_chk++; if (lat !== 21) $display("FAIL rmid_rerun_latency: got %0d want 21", lat); else n_pass++;
        n_chk++; if (out_blk !== PT_C1) $display("FAIL rmid_rerun_pt: got %h want %h", out_blk, PT_C1); else n_pass++;
        handshake();
    endtask

    task automatic test_back_to_back;
        int lat, hs, acc;
        logic [127:0] ct_b, key_b, exp_b, got_a;
        ct_b  = {$urandom(), $urandom(), $urandom(), $urandom()};
        key_b = {$urandom(), $urandom(), $urandom(), $urandom()};
        exp_b = ref_decrypt(ct_b, key_b);
        got_a = '0;
        hs = -1; acc = -1;
        out_ready = 1'b1;
        ct_in = CT_C1; key_in = KEY_C1; in_valid = 1'b1;
        @(posedge clk); #1;
        ct_in = ct_b; key_in = key_b;
        for (int i = 0; i < 60; i++) begin
            if (hs < 0 && out_valid) begin
                hs    = i;
                got_a = out_blk;
            end else if (hs >= 0 && in_ready) begin
                acc = i;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_chk++; if (got_a !== PT_C1) $display("FAIL b2b_first_pt: got %h want %h", got_a, PT_C1); else n_pass++;
        n_chk++; if (hs < 0 || acc - hs !== 1) $display("FAIL b2b_accept_gap: got %0d want 1 (hs=%0d)", acc - hs, hs); else n_pass++;
        wait_out(lat);
        n_chk++; if (lat !== 21) $display("FAIL b2b_second_latency: got %0d want 21", lat); else n_pass++;
        n_chk++; if (out_blk !== exp_b) $display("FAIL b2b_second_pt: got %h want %h", out_blk, exp_b); else n_pass++;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL b2b_drain: got %b want 0", out_valid); else n_pass++;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        ct_in = '0; key_in = '0;
        build_sbox();
        test_reset();
        test_fips_c1();
        test_fips_b();
        test_loopback();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
